// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, responder FSM states and the byte-lane helper used by the
// memory responder and its RAM.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    SizeByte = 3'b000,
    SizeHalf = 3'b001,
    SizeWord = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StDone,
    StErr1,
    StErr2
  } state_t;

  // Little-endian lane enables; illegal sizes select no lanes.
  function automatic logic [3:0] be_from(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      SizeByte: be = 4'b0001 << addr;
      SizeHalf: be = addr[1] ? 4'b1100 : 4'b0011;
      SizeWord: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised RAM with a byte-enable write port and a registered read port that
// forwards same-edge write data so a read sees the post-write word.
module ahb_mem_array
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] fwd;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    fwd = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) fwd[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= fwd;
    end
  end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-lite memory responder: configurable wait states before OKAY completions and a
// two-cycle ERROR response for out-of-range or misaligned transfers.
module ahb_mem_responder
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA
);

  localparam int unsigned     AW        = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ByteLimit = (ADDR_W + 1)'(DEPTH * 4);
  localparam logic [3:0]      WaitLoad  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;

  logic          ready;
  logic          accept;
  logic          req_err;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;

  // Burst type and the BUSY/IDLE distinction carry no meaning for a plain memory.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST};

  assign ready  = (state_q != StWait) && (state_q != StErr1);
  assign accept = HSEL && HREADY && HTRANS[1] && ready;

  assign req_err = ({1'b0, HADDR} >= ByteLimit)
                || (HSIZE > SizeWord)
                || ((HSIZE == SizeHalf) && HADDR[0])
                || ((HSIZE == SizeWord) && (HADDR[1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_re    = 1'b0;
    mem_raddr = HADDR[AW+1:2];
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d   = StDone;
          mem_re    = !write_q;
          mem_raddr = addr_q[AW+1:2];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        // StIdle, StDone and StErr2 all present HREADYOUT=1 and may take a new transfer.
        if (accept) begin
          if (req_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StDone;
            mem_re  = !HWRITE;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Commit happens at the end of DONE; a reset on that edge abandons it.
  assign mem_we = !HRESET && (state_q == StDone) && write_q;

  ahb_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (mem_we),
    .be    (be_from(size_q, addr_q[1:0])),
    .waddr (addr_q[AW+1:2]),
    .wdata (HWDATA),
    .re    (mem_re && !HRESET),
    .raddr (mem_raddr),
    .rdata (HRDATA)
  );

  assign HREADYOUT = ready;
  assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? RespError : RespOkay;

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Drives two responders (0 and 2 wait states) as a pipelined AHB master and checks every
// cycle against a byte-array memory model.
module tb_ahb_mem_responder;

  localparam logic [31:0] ByteSpan = 32'd4096;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  logic        HCLK;
  logic        hreset    [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];
  logic [31:0] hrdata    [2];

  int          n_vec;
  int          n_err;
  item_t       seq_q [$];
  logic [7:0]  ref_mem [2][4096];
  logic [31:0] hrdata_exp [2];

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_mem_responder #(.DEPTH(1024), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
    .HCLK(HCLK), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
    .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_mem_responder #(.DEPTH(1024), .WAIT_STATES(2), .ADDR_W(32)) u_dut1 (
    .HCLK(HCLK), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
    .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit is_err(input item_t it);
    if (it.addr >= ByteSpan) return 1'b1;
    if (it.size > 3'd2) return 1'b1;
    if (it.size == 3'd1 && it.addr[0]) return 1'b1;
    if (it.size == 3'd2 && it.addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit lane_hit(input logic [2:0] size, input int off, input int b);
    if (size == 3'd0) return b == off;
    if (size == 3'd1) return (b / 2) == (off / 2);
    return 1'b1;
  endfunction

  task automatic model_write(input int d, input item_t it);
    int base;
    int off;
    base = int'(it.addr & 32'hFFFF_FFFC);
    off  = int'(it.addr[1:0]);
    for (int b = 0; b < 4; b++) begin
      if (lane_hit(it.size, off, b)) ref_mem[d][base + b] = it.wdata[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
    int base;
    base = int'(addr & 32'hFFFF_FFFC);
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  task automatic push(input logic [1:0] trans, input logic write, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] val, input logic [2:0] burst);
    item_t it;
    it.trans = trans;
    it.write = write;
    it.size  = size;
    it.burst = burst;
    it.addr  = addr;
    it.wdata = (size < 3'd2) ? (val << (8 * int'(addr[1:0]))) : val;
    seq_q.push_back(it);
  endtask

  task automatic drive_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    haddr[d]  = '0;
    hwrite[d] = 1'b0;
    hsize[d]  = 3'd0;
    hburst[d] = 3'd0;
  endtask

  // Pipelined master: address of the next item overlaps the data phase of the current one.
  task automatic run_seq(input int d);
    item_t addr_it;
    item_t data_it;
    bit    addr_v;
    bit    data_v;
    bit    err;
    logic  ready;
    int    lowc;
    int    budget;
    addr_v = 1'b0;
    data_v = 1'b0;
    lowc   = 0;
    budget = 50 * (seq_q.size() + 2);
    if (seq_q.size() > 0) begin
      addr_it = seq_q.pop_front();
      addr_v  = 1'b1;
    end
    while ((addr_v || data_v) && budget > 0) begin
      @(negedge HCLK);
      budget--;
      if (addr_v) begin
        hsel[d]   = 1'b1;
        htrans[d] = addr_it.trans;
        haddr[d]  = addr_it.addr;
        hwrite[d] = addr_it.write;
        hsize[d]  = addr_it.size;
        hburst[d] = addr_it.burst;
      end else begin
        drive_idle(d);
      end
      hwdata[d] = data_v ? data_it.wdata : 32'h0;
      ready = hreadyout[d];
      if (data_v) begin
        err = is_err(data_it);
        if (ready) begin
          if (!err && !data_it.write) hrdata_exp[d] = model_read(d, data_it.addr);
          check_eq($sformatf("d%0d_resp_done", d), 32'(hresp[d]), err ? 32'd1 : 32'd0);
          check_eq($sformatf("d%0d_wait_cycles", d), 32'(lowc), err ? 32'd1 : 32'(ws_of(d)));
          if (!err && data_it.write) model_write(d, data_it);
          data_v = 1'b0;
        end else begin
          lowc++;
          check_eq($sformatf("d%0d_resp_stall", d), 32'(hresp[d]), err ? 32'd1 : 32'd0);
        end
      end else begin
        check_eq($sformatf("d%0d_idle_ready", d), 32'(ready), 32'd1);
        check_eq($sformatf("d%0d_idle_resp", d), 32'(hresp[d]), 32'd0);
      end
      check_eq($sformatf("d%0d_rdata", d), hrdata[d], hrdata_exp[d]);
      if (ready) begin
        if (addr_v && addr_it.trans[1]) begin
          data_it = addr_it;
          data_v  = 1'b1;
          lowc    = 0;
        end
        addr_v = 1'b0;
        if (seq_q.size() > 0) begin
          addr_it = seq_q.pop_front();
          addr_v  = 1'b1;
        end
      end
    end
    if (budget == 0) check_eq($sformatf("d%0d_timeout", d), 32'd1, 32'd0);
    seq_q.delete();
    @(negedge HCLK);
    drive_idle(d);
    hwdata[d] = 32'h0;
  endtask

  task automatic gen_random(input int n);
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < n; i++) begin
      r  = int'($urandom_range(0, 99));
      tr = (r < 12) ? 2'($urandom_range(0, 1)) : 2'(2 + $urandom_range(0, 1));
      r  = int'($urandom_range(0, 99));
      sz = (r < 6) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 99));
      if (r < 8) a = 32'h1000 + 32'($urandom_range(0, 4095));
      else if (r < 10) a = $urandom;
      else a = 32'($urandom_range(0, 255));
      // Mostly keep legal alignment so reads and writes actually land.
      if (r >= 10 && $urandom_range(0, 4) != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      push(tr, 1'($urandom_range(0, 1)), sz, a, $urandom, 3'd0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      hwdata[d]     = 32'h0;
      hreset[d]     = 1'b1;
      hrdata_exp[d] = 32'h0;
    end
    repeat (3) @(negedge HCLK);
    hreset[0] = 1'b0;
    hreset[1] = 1'b0;
    @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), 32'(hreadyout[d]), 32'd1);
      check_eq($sformatf("d%0d_rst_resp", d), 32'(hresp[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_rdata", d), hrdata[d], 32'd0);
    end

    // Fill a known region so every later read has a defined expectation.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) push(2'b10, 1'b1, 3'd2, 32'(4 * w), $urandom, 3'd0);
      run_seq(d);
    end

    // Write then read back-to-back, zero wait states.
    push(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 3'd0);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 3'd0);
    run_seq(0);
    check_eq("d0_deadbeef", hrdata[0], 32'hDEADBEEF);

    // Two-wait-state read.
    push(2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 3'd0);
    run_seq(1);

    // Byte lane merge.
    push(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344, 3'd0);
    push(2'b10, 1'b1, 3'd0, 32'h13, 32'hAA, 3'd0);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 3'd0);
    run_seq(0);
    check_eq("d0_byte_merge", hrdata[0], 32'hAA223344);

    // Out-of-range and misaligned accesses, then confirm word 0 untouched.
    for (int d = 0; d < 2; d++) begin
      push(2'b10, 1'b1, 3'd2, 32'h1000, 32'hBAD0BAD0, 3'd0);
      push(2'b10, 1'b1, 3'd2, 32'h2, 32'hBAD1BAD1, 3'd0);
      push(2'b10, 1'b1, 3'd1, 32'h5, 32'hBAD2, 3'd0);
      push(2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 3'd0);
      run_seq(d);
    end

    // INCR4 burst with a BUSY beat, then readback.
    for (int d = 0; d < 2; d++) begin
      push(2'b10, 1'b1, 3'd2, 32'h100, 32'hA0A0A0A0, 3'd3);
      push(2'b11, 1'b1, 3'd2, 32'h104, 32'hA1A1A1A1, 3'd3);
      push(2'b01, 1'b1, 3'd2, 32'h108, 32'hEEEEEEEE, 3'd3);
      push(2'b11, 1'b1, 3'd2, 32'h108, 32'hA2A2A2A2, 3'd3);
      push(2'b11, 1'b1, 3'd2, 32'h10C, 32'hA3A3A3A3, 3'd3);
      for (int w = 0; w < 4; w++) push(2'b10, 1'b0, 3'd2, 32'h100 + 32'(4 * w), 32'h0, 3'd0);
      run_seq(d);
    end
    check_eq("d1_burst_last", hrdata[1], 32'hA3A3A3A3);

    for (int d = 0; d < 2; d++) begin
      gen_random(300);
      run_seq(d);
    end

    // Reset in the middle of a stalled write: no commit, HRDATA cleared.
    push(2'b10, 1'b0, 3'd2, 32'h24, 32'h0, 3'd0);
    run_seq(1);
    @(negedge HCLK);
    hsel[1]   = 1'b1;
    htrans[1] = 2'b10;
    hwrite[1] = 1'b1;
    hsize[1]  = 3'd2;
    haddr[1]  = 32'h20;
    @(negedge HCLK);
    check_eq("d1_rst_in_wait", 32'(hreadyout[1]), 32'd0);
    drive_idle(1);
    hwdata[1] = 32'h12345678;
    hreset[1] = 1'b1;
    @(negedge HCLK);
    hreset[1] = 1'b0;
    hwdata[1] = 32'h0;
    check_eq("d1_rst_mid_ready", 32'(hreadyout[1]), 32'd1);
    check_eq("d1_rst_mid_resp", 32'(hresp[1]), 32'd0);
    check_eq("d1_rst_mid_rdata", hrdata[1], 32'd0);
    hrdata_exp[1] = 32'h0;
    push(2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 3'd0);
    run_seq(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
